// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state and port encodings.
// INTERNAL_BITS falls back to 32 when the CPU build has not set it already.
`ifndef INTERNAL_BITS
`define INTERNAL_BITS 32
`endif

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_IF   = 2'b01,
        ARB_D    = 2'b10
    } arb_state_e;

    typedef enum logic {
        ARB_PORT_IF = 1'b0,
        ARB_PORT_D  = 1'b1
    } arb_port_e;

    localparam int ARB_DATA_BITS = `INTERNAL_BITS;

    function automatic arb_port_e arb_other_port(arb_port_e p);
        return (p == ARB_PORT_D) ? ARB_PORT_IF : ARB_PORT_D;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF/MEM request ports, memory-side signals and stall.
// The master side is the pipeline plus memory; the slave side is the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = `INTERNAL_BITS
);
    logic                 if_req;
    logic [ADDR_BITS-1:0] if_addr;
    logic                 if_flush;
    logic [DATA_BITS-1:0] if_rdata;
    logic                 if_ready;
    logic                 d_req;
    logic                 d_we;
    logic [ADDR_BITS-1:0] d_addr;
    logic [DATA_BITS-1:0] d_wdata;
    logic [DATA_BITS-1:0] d_rdata;
    logic                 d_ready;
    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [DATA_BITS-1:0] mem_rdata;
    logic                 stall;

    modport master (
        output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport slave (
        input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter_arb_grant_sel.sv
// Combinational winner select between the fetch and data ports.
// MEM_ARB_RR_EN: round-robin on contention via rr_ptr; otherwise data always wins.
module arb_grant_sel
    import mem_port_arbiter_pkg::*;
(
    input  logic      if_req,
    input  logic      d_req,
`ifdef MEM_ARB_RR_EN
    input  arb_port_e rr_ptr,
`endif
    output logic      gnt_valid,
    output arb_port_e gnt_port
);

    always_comb begin
        gnt_valid = if_req | d_req;
        gnt_port  = ARB_PORT_D;
`ifdef MEM_ARB_RR_EN
        if (if_req && d_req) begin
            gnt_port = rr_ptr;
        end else if (if_req) begin
            gnt_port = ARB_PORT_IF;
        end
`else
        if (if_req && !d_req) begin
            gnt_port = ARB_PORT_IF;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between instruction fetch and data access.
// MEM_ARB_RR_EN selects round-robin arbitration; undefined gives fixed data priority.
//
// state    | meaning
// ARB_IDLE | arbitration cycle, memory idle
// ARB_IF   | fetch access in flight, MEM_LAT cycles
// ARB_D    | load/store access in flight, MEM_LAT cycles
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = `INTERNAL_BITS,
    parameter int MEM_LAT   = 2
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam int                  CNT_BITS = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MEM_LAT - 1);

    arb_state_e          state;
    logic [CNT_BITS-1:0] cnt;
    logic                if_cancel;
    logic                if_pend;
    logic                d_pend;
    logic                gnt_valid;
    arb_port_e           gnt_port;

    // A port whose ready pulses this cycle is finished; masking it blocks a duplicate grant.
    assign if_pend   = bus.if_req & ~bus.if_ready;
    assign d_pend    = bus.d_req & ~bus.d_ready;
    assign bus.stall = ~rst & (if_pend | d_pend);

`ifdef MEM_ARB_RR_EN
    arb_port_e rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= ARB_PORT_D;
        end else if (state == ARB_IDLE && gnt_valid) begin
            rr_ptr <= arb_other_port(gnt_port);
        end
    end

    arb_grant_sel u_grant_sel (
        .if_req    (if_pend),
        .d_req     (d_pend),
        .rr_ptr    (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );
`else
    arb_grant_sel u_grant_sel (
        .if_req    (if_pend),
        .d_req     (d_pend),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ARB_IDLE;
            cnt           <= '0;
            if_cancel     <= 1'b0;
            bus.if_rdata  <= '0;
            bus.if_ready  <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_ready   <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.if_ready <= 1'b0;
            bus.d_ready  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (gnt_valid) begin
                        cnt        <= CNT_LOAD;
                        if_cancel  <= 1'b0;
                        bus.mem_en <= 1'b1;
                        if (gnt_port == ARB_PORT_D) begin
                            state         <= ARB_D;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_addr  <= ADDR_BITS'(bus.d_addr);
                            bus.mem_wdata <= DATA_BITS'(bus.d_wdata);
                        end else begin
                            state        <= ARB_IF;
                            bus.mem_we   <= 1'b0;
                            bus.mem_addr <= ADDR_BITS'(bus.if_addr);
                        end
                    end
                end
                ARB_IF: begin
                    if (cnt == '0) begin
                        state      <= ARB_IDLE;
                        bus.mem_en <= 1'b0;
                        if_cancel  <= 1'b0;
                        // A redirected fetch still finishes on the memory, but nobody wants its word.
                        if (!(if_cancel || bus.if_flush)) begin
                            bus.if_rdata <= DATA_BITS'(bus.mem_rdata);
                            bus.if_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_BITS'(1);
                        if (bus.if_flush) begin
                            if_cancel <= 1'b1;
                        end
                    end
                end
                ARB_D: begin
                    if (cnt == '0) begin
                        state       <= ARB_IDLE;
                        bus.mem_en  <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        bus.d_ready <= 1'b1;
                        if (!bus.mem_we) begin
                            bus.d_rdata <= DATA_BITS'(bus.mem_rdata);
                        end
                    end else begin
                        cnt <= cnt - CNT_BITS'(1);
                    end
                end
                default: begin
                    state      <= ARB_IDLE;
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2 and a small memory model.
// Expectations for contended grants follow MEM_ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_port_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(32)) bus ();

    mem_port_arbiter #(.ADDR_BITS(16), .DATA_BITS(32), .MEM_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: fixed contents unless overwritten by a store.
    logic [31:0] wmem   [1024];
    logic        wvalid [1024];
    logic [9:0]  maddr;

    function automatic logic [31:0] rom_word(logic [9:0] a);
        if (a == 10'h010) return 32'h8C220004;
        return {16'hC0DE, 6'b0, a};
    endfunction

    assign maddr         = bus.mem_addr[9:0];
    assign bus.mem_rdata = (wvalid[maddr] === 1'b1) ? wmem[maddr] : rom_word(maddr);

    always @(posedge clk) begin
        if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) begin
            wmem[maddr]   <= bus.mem_wdata;
            wvalid[maddr] <= 1'b1;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (2) @(negedge clk);
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        n_cmp++; if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en: got %b want 0", bus.mem_en); end
        n_cmp++; if ({bus.if_ready, bus.d_ready, bus.mem_we} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {bus.if_ready, bus.d_ready, bus.mem_we}); end
        n_cmp++; if ({bus.if_rdata, bus.d_rdata} !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", {bus.if_rdata, bus.d_rdata}); end
        n_cmp++; if (bus.mem_addr !== 16'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0000", bus.mem_addr); end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.stall, bus.mem_en} !== 2'b00) begin n_err++; $display("FAIL reset_idle: got %b want 00", {bus.stall, bus.mem_en}); end
    endtask

    task automatic test_fetch();
        @(negedge clk);
        bus.if_addr = 16'h0010; bus.if_req = 1'b1;
        #1;
        n_cmp++; if ({bus.stall, bus.mem_en} !== 2'b10) begin n_err++; $display("FAIL fetch_c0: stall/en got %b want 10", {bus.stall, bus.mem_en}); end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_cmp++; if ({bus.mem_en, bus.mem_we, bus.stall, bus.if_ready} !== 4'b1010) begin n_err++; $display("FAIL fetch_c%0d_ctl: en/we/stall/rdy got %b want 1010", c, {bus.mem_en, bus.mem_we, bus.stall, bus.if_ready}); end
            n_cmp++; if (bus.mem_addr !== 16'h0010) begin n_err++; $display("FAIL fetch_c%0d_addr: got %h want 0010", c, bus.mem_addr); end
        end
        @(negedge clk);
        n_cmp++; if ({bus.if_ready, bus.mem_en, bus.stall} !== 3'b100) begin n_err++; $display("FAIL fetch_c3_ctl: rdy/en/stall got %b want 100", {bus.if_ready, bus.mem_en, bus.stall}); end
        n_cmp++; if (bus.if_rdata !== 32'h8C220004) begin n_err++; $display("FAIL fetch_c3_data: got %h want 8c220004", bus.if_rdata); end
        bus.if_req = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.if_ready, bus.mem_en} !== 2'b00) begin n_err++; $display("FAIL fetch_c4: rdy/en got %b want 00", {bus.if_ready, bus.mem_en}); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        bus.if_addr = 16'h0030; bus.if_req = 1'b1;
        bus.d_addr = 16'h0100; bus.d_we = 1'b0; bus.d_req = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_cmp++; if ({bus.mem_en, bus.mem_addr} !== {1'b1, 16'h0100}) begin n_err++; $display("FAIL prio_d_c%0d: en/addr got %b/%h want 1/0100", c, bus.mem_en, bus.mem_addr); end
        end
        @(negedge clk);
        n_cmp++; if ({bus.d_ready, bus.if_ready, bus.stall} !== 3'b101) begin n_err++; $display("FAIL prio_c3: drdy/irdy/stall got %b want 101", {bus.d_ready, bus.if_ready, bus.stall}); end
        n_cmp++; if (bus.d_rdata !== 32'hC0DE0100) begin n_err++; $display("FAIL prio_d_data: got %h want c0de0100", bus.d_rdata); end
        bus.d_req = 1'b0;
        for (int c = 4; c <= 5; c++) begin
            @(negedge clk);
            n_cmp++; if ({bus.mem_en, bus.stall, bus.mem_addr} !== {2'b11, 16'h0030}) begin n_err++; $display("FAIL prio_if_c%0d: en/stall/addr got %b%b/%h want 11/0030", c, bus.mem_en, bus.stall, bus.mem_addr); end
        end
        @(negedge clk);
        n_cmp++; if ({bus.if_ready, bus.stall} !== 2'b10) begin n_err++; $display("FAIL prio_c6: irdy/stall got %b want 10", {bus.if_ready, bus.stall}); end
        n_cmp++; if (bus.if_rdata !== 32'hC0DE0030) begin n_err++; $display("FAIL prio_if_data: got %h want c0de0030", bus.if_rdata); end
        bus.if_req = 1'b0;
    endtask

    task automatic test_store();
        bit got;
        @(negedge clk);
        bus.d_addr = 16'h0020; bus.d_wdata = 32'hDEADBEEF; bus.d_we = 1'b1; bus.d_req = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_cmp++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b11, 16'h0020}) begin n_err++; $display("FAIL store_c%0d_ctl: en/we/addr got %b%b/%h want 11/0020", c, bus.mem_en, bus.mem_we, bus.mem_addr); end
            n_cmp++; if (bus.mem_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL store_c%0d_wdata: got %h want deadbeef", c, bus.mem_wdata); end
        end
        @(negedge clk);
        n_cmp++; if ({bus.d_ready, bus.mem_en, bus.mem_we} !== 3'b100) begin n_err++; $display("FAIL store_c3: rdy/en/we got %b want 100", {bus.d_ready, bus.mem_en, bus.mem_we}); end
        n_cmp++; if (bus.d_rdata !== 32'hC0DE0100) begin n_err++; $display("FAIL store_rdata_kept: got %h want c0de0100", bus.d_rdata); end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        @(negedge clk);
        bus.d_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.d_ready === 1'b1) got = 1'b1;
        end
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL load_after_store_timeout: ready seen %b want 1", got); end
        n_cmp++; if (bus.d_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_after_store_data: got %h want deadbeef", bus.d_rdata); end
        bus.d_req = 1'b0;
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.if_addr = 16'h0040; bus.if_req = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.mem_en, bus.mem_addr} !== {1'b1, 16'h0040}) begin n_err++; $display("FAIL flush_c1: en/addr got %b/%h want 1/0040", bus.mem_en, bus.mem_addr); end
        @(negedge clk);
        n_cmp++; if (bus.mem_en !== 1'b1) begin n_err++; $display("FAIL flush_c2_en: got %b want 1", bus.mem_en); end
        bus.if_flush = 1'b1;
        @(negedge clk);
        bus.if_flush = 1'b0;
        n_cmp++; if ({bus.if_ready, bus.mem_en, bus.stall} !== 3'b001) begin n_err++; $display("FAIL flush_c3: rdy/en/stall got %b want 001", {bus.if_ready, bus.mem_en, bus.stall}); end
        bus.if_addr = 16'h0044;
        for (int c = 4; c <= 5; c++) begin
            @(negedge clk);
            n_cmp++; if ({bus.mem_en, bus.if_ready, bus.mem_addr} !== {2'b10, 16'h0044}) begin n_err++; $display("FAIL flush_refetch_c%0d: en/rdy/addr got %b%b/%h want 10/0044", c, bus.mem_en, bus.if_ready, bus.mem_addr); end
        end
        @(negedge clk);
        n_cmp++; if ({bus.if_ready, bus.if_rdata} !== {1'b1, 32'hC0DE0044}) begin n_err++; $display("FAIL flush_refetch_done: rdy/data got %b/%h want 1/c0de0044", bus.if_ready, bus.if_rdata); end
        bus.if_req = 1'b0;
        // A flush seen while idle must not cancel the fetch granted in that cycle.
        @(negedge clk);
        bus.if_addr = 16'h0010; bus.if_req = 1'b1; bus.if_flush = 1'b1;
        @(negedge clk);
        bus.if_flush = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({bus.if_ready, bus.if_rdata} !== {1'b1, 32'h8C220004}) begin n_err++; $display("FAIL flush_idle_noeffect: rdy/data got %b/%h want 1/8c220004", bus.if_ready, bus.if_rdata); end
        bus.if_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.d_addr = 16'h0100; bus.d_we = 1'b0; bus.d_req = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.mem_en !== 1'b1) begin n_err++; $display("FAIL rstmid_before: en got %b want 1", bus.mem_en); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({bus.mem_en, bus.stall, bus.d_ready, bus.d_rdata} !== 35'h0) begin n_err++; $display("FAIL rstmid_clear: en/stall/rdy got %b%b%b data %h want 000/0", bus.mem_en, bus.stall, bus.d_ready, bus.d_rdata); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if ({bus.stall, bus.mem_en} !== 2'b10) begin n_err++; $display("FAIL rstmid_release: stall/en got %b want 10", {bus.stall, bus.mem_en}); end
        for (int c = 3; c <= 4; c++) begin
            @(negedge clk);
            n_cmp++; if ({bus.mem_en, bus.d_ready} !== 2'b10) begin n_err++; $display("FAIL rstmid_c%0d: en/rdy got %b want 10", c, {bus.mem_en, bus.d_ready}); end
        end
        @(negedge clk);
        n_cmp++; if ({bus.d_ready, bus.d_rdata} !== {1'b1, 32'hC0DE0100}) begin n_err++; $display("FAIL rstmid_done: rdy/data got %b/%h want 1/c0de0100", bus.d_ready, bus.d_rdata); end
        bus.d_req = 1'b0;
    endtask

    task automatic test_arbitration();
        int  first;
        bit  seen_d, seen_if, got;
        int  exp_first [2];
        exp_first[0] = 1;
`ifdef MEM_ARB_RR_EN
        exp_first[1] = 0;
`else
        exp_first[1] = 1;
`endif
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
                // A lone data grant leaves a round-robin pointer aimed at fetch.
                @(negedge clk);
                bus.d_addr = 16'h0100; bus.d_we = 1'b0; bus.d_req = 1'b1;
                got = 1'b0;
                for (int i = 0; i < 10 && !got; i++) begin
                    @(negedge clk);
                    if (bus.d_ready === 1'b1) got = 1'b1;
                end
                n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL arb_single_d_timeout: ready seen %b want 1", got); end
                bus.d_req = 1'b0;
            end
            @(negedge clk);
            bus.d_addr = 16'h0100; bus.d_we = 1'b0; bus.d_req = 1'b1;
            bus.if_addr = 16'h0030; bus.if_req = 1'b1;
            first = -1; seen_d = 1'b0; seen_if = 1'b0;
            for (int i = 0; i < 20 && !(seen_d && seen_if); i++) begin
                @(negedge clk);
                if (bus.d_ready === 1'b1) begin
                    if (first < 0) first = 1;
                    seen_d = 1'b1; bus.d_req = 1'b0;
                end
                if (bus.if_ready === 1'b1) begin
                    if (first < 0) first = 0;
                    seen_if = 1'b1; bus.if_req = 1'b0;
                end
            end
            n_cmp++; if ({seen_d, seen_if} !== 2'b11) begin n_err++; $display("FAIL arb_round%0d_timeout: d/if served %b want 11", r, {seen_d, seen_if}); end
            n_cmp++; if (first != exp_first[r]) begin n_err++; $display("FAIL arb_round%0d_winner: got %0d want %0d (1=D 0=IF)", r, first, exp_first[r]); end
            n_cmp++; if ({bus.d_rdata, bus.if_rdata} !== {32'hC0DE0100, 32'hC0DE0030}) begin n_err++; $display("FAIL arb_round%0d_data: got %h/%h want c0de0100/c0de0030", r, bus.d_rdata, bus.if_rdata); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_flush();
        test_reset_mid();
        test_arbitration();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
